// File: rtl/regfile_write_queue_pkg.sv
// rtl/regfile_write_queue_pkg.sv - shared types for the register file write queue
package regfile_write_queue_pkg;

   // Data word and register index as used by the register file.
   typedef logic [31:0] word_t;
   typedef logic [4:0]  regbits_t;

   // One pending register writeback.
   typedef struct packed {
      regbits_t wsel;
      word_t    wdat;
   } wbq_entry_t;

   localparam int unsigned WBQ_DEFAULT_DEPTH = 4;

   // r0 is hardwired; writes to it are dropped and it never forwards.
   function automatic logic is_real_reg(input regbits_t sel);
      return sel != '0;
   endfunction

endpackage

// File: rtl/regfile_write_queue_if.sv
// rtl/regfile_write_queue_if.sv - push, drain and lookup signals of the write queue
interface regfile_write_queue_if
   import regfile_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH = WBQ_DEFAULT_DEPTH
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   // Writeback side
   logic             push_valid;
   regbits_t         push_wsel;
   word_t            push_wdat;
   logic             push_ready;

   // Register file write port
   logic             hold;
   logic             WEN;
   regbits_t         wsel;
   word_t            wdat;

   // Forwarding lookups
   regbits_t         rsel1;
   regbits_t         rsel2;
   logic             fwd_hit1;
   word_t            fwd_dat1;
   logic             fwd_hit2;
   word_t            fwd_dat2;

   // Occupancy
   logic [CNT_W-1:0] count;

   // Pipeline / register file side
   modport master (
      output push_valid, push_wsel, push_wdat, hold, rsel1, rsel2,
      input  push_ready, WEN, wsel, wdat,
      input  fwd_hit1, fwd_dat1, fwd_hit2, fwd_dat2, count
   );

   // Queue side
   modport slave (
      input  push_valid, push_wsel, push_wdat, hold, rsel1, rsel2,
      output push_ready, WEN, wsel, wdat,
      output fwd_hit1, fwd_dat1, fwd_hit2, fwd_dat2, count
   );

endinterface

// File: rtl/regfile_wq_fwd_match.sv
// rtl/regfile_wq_fwd_match.sv - youngest pending write lookup for one read select
module regfile_wq_fwd_match
   import regfile_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH = WBQ_DEFAULT_DEPTH
) (
   input  wbq_entry_t [DEPTH-1:0]         entries_i,
   input  logic [DEPTH-1:0]               valid_i,
   input  logic [$clog2(DEPTH)-1:0]       head_i,
   input  regbits_t                       rsel_i,
   output logic                           hit_o,
   output word_t                          dat_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] idx;

   // Walk from head (oldest) toward tail so the last match seen is the youngest.
   always_comb begin
      hit_o = 1'b0;
      dat_o = '0;
      idx   = head_i;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i + PTR_W'(k);
         if (valid_i[idx] && is_real_reg(rsel_i) && (entries_i[idx].wsel == rsel_i)) begin
            hit_o = 1'b1;
            dat_o = entries_i[idx].wdat;
         end
      end
   end

endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - in-order writeback queue draining into the register file
module regfile_write_queue
   import regfile_write_queue_pkg::*;
#(
   parameter int unsigned DEPTH = WBQ_DEFAULT_DEPTH
) (
   input  logic                   CLK,
   input  logic                   nRST,
   regfile_write_queue_if.slave   bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wbq_entry_t [DEPTH-1:0] entries_q, entries_d;
   logic [DEPTH-1:0]       valid_q, valid_d;
   logic [PTR_W-1:0]       head_q, head_d;
   logic [PTR_W-1:0]       tail_q, tail_d;
   logic [CNT_W-1:0]       count_q, count_d;

   logic                   pop;
   logic                   push_ready;
   logic                   push_acc;
   wbq_entry_t             head_entry;

   // Drain whenever something is queued and the write port is free.
   assign pop        = (count_q != '0) && !bus.hold;
   // A full queue still accepts a push in a cycle where the head leaves.
   assign push_ready = (count_q != CNT_W'(DEPTH)) || pop;
   // r0 pushes are acknowledged but never stored.
   assign push_acc   = bus.push_valid && push_ready && is_real_reg(bus.push_wsel);
   assign head_entry = entries_q[head_q];

   assign bus.push_ready = push_ready;
   assign bus.WEN        = pop;
   assign bus.wsel       = pop ? head_entry.wsel : '0;
   assign bus.wdat       = pop ? head_entry.wdat : '0;
   assign bus.count      = count_q;

   // Next-state: pop clears the head slot first, so a same-slot push on a full queue wins.
   always_comb begin
      entries_d = entries_q;
      valid_d   = valid_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;

      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + PTR_W'(1);
      end

      if (push_acc) begin
         entries_d[tail_q].wsel = bus.push_wsel;
         entries_d[tail_q].wdat = bus.push_wdat;
         valid_d[tail_q]        = 1'b1;
         tail_d                 = tail_q + PTR_W'(1);
      end

      case ({push_acc, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue state; reset discards every pending write.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         entries_q <= '0;
         valid_q   <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         entries_q <= entries_d;
         valid_q   <= valid_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   regfile_wq_fwd_match #(
      .DEPTH     (DEPTH)
   ) u_fwd1 (
      .entries_i (entries_q),
      .valid_i   (valid_q),
      .head_i    (head_q),
      .rsel_i    (bus.rsel1),
      .hit_o     (bus.fwd_hit1),
      .dat_o     (bus.fwd_dat1)
   );

   regfile_wq_fwd_match #(
      .DEPTH     (DEPTH)
   ) u_fwd2 (
      .entries_i (entries_q),
      .valid_i   (valid_q),
      .head_i    (head_q),
      .rsel_i    (bus.rsel2),
      .hit_o     (bus.fwd_hit2),
      .dat_o     (bus.fwd_dat2)
   );

endmodule
